// File: rtl/even_issue_scheduler.sv
// even_issue_scheduler
// --------------------
// Issue gate for the even pipe. A per-register pending-latency scoreboard
// holds back any instruction that reads a register whose producer result is
// not yet forwardable. Accepted instructions are registered onto the out_*
// bus for one cycle.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   decoded instruction handshake; in_ready = no hazard
//   instr_id, unit_id   opcode ID and target unit of the offered instruction
//   reg_dst, latency    destination register and result latency
//   reg_wr              instruction writes reg_dst
//   r{a,b,c}_addr/_use  source registers and whether each is really read
//   odd_set_*           writing instruction issued by the odd pipe
//   out_*               registered issued instruction fields, out_valid strobe
//   busy                some scoreboard counter is still nonzero
//   stall_count         saturating count of cycles an offered instr stalled

module even_issue_scheduler #(
    parameter int NUM_REGS = 128,
    parameter int MAX_LAT  = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  instr_id,
    input  logic [2:0]  unit_id,
    input  logic [6:0]  reg_dst,
    input  logic [3:0]  latency,
    input  logic        reg_wr,
    input  logic [6:0]  ra_addr,
    input  logic [6:0]  rb_addr,
    input  logic [6:0]  rc_addr,
    input  logic        ra_use,
    input  logic        rb_use,
    input  logic        rc_use,
    input  logic        odd_set_valid,
    input  logic [6:0]  odd_set_dst,
    input  logic [3:0]  odd_set_latency,
    output logic        out_valid,
    output logic [6:0]  out_instr_id,
    output logic [2:0]  out_unit_id,
    output logic [6:0]  out_reg_dst,
    output logic [3:0]  out_latency,
    output logic        out_reg_wr,
    output logic        busy,
    output logic [31:0] stall_count
);

    localparam logic [3:0] MAX_LAT_L = 4'(MAX_LAT);
    localparam logic [6:0] ID_NOP    = 7'd86;
    localparam logic [6:0] ID_LNOP   = 7'd87;

    // Pending cycles until each register's value can be forwarded.
    logic [2:0] cnt [NUM_REGS];

    logic                accept;
    logic                hazard;
    logic                is_nop;
    logic                even_load;
    logic [2:0]          even_val;
    logic [2:0]          odd_val;
    logic [NUM_REGS-1:0] even_hit;
    logic [NUM_REGS-1:0] odd_hit;

    // Latency is clamped into 1..MAX_LAT; the counter holds latency-1 so a
    // latency-1 (or 0) producer never blocks the very next instruction.
    function automatic logic [2:0] load_value(input logic [3:0] lat);
        logic [3:0] l;
        if (lat == 4'd0)
            l = 4'd1;
        else if (lat > MAX_LAT_L)
            l = MAX_LAT_L;
        else
            l = lat;
        return 3'(l - 4'd1);
    endfunction

    // Hazard looks only at the current counters, so a load landing on this
    // same edge cannot block the instruction being offered now.
    always_comb begin
        hazard = (ra_use && cnt[ra_addr] != 3'd0) ||
                 (rb_use && cnt[rb_addr] != 3'd0) ||
                 (rc_use && cnt[rc_addr] != 3'd0);
        in_ready  = !hazard;
        accept    = in_valid && in_ready;
        is_nop    = (instr_id == ID_NOP) || (instr_id == ID_LNOP);
        even_load = accept && reg_wr && !is_nop;
        even_val  = load_value(latency);
        odd_val   = load_value(odd_set_latency);
    end

    // One-hot decode of which registers get loaded from each pipe this edge.
    always_comb begin
        even_hit = '0;
        odd_hit  = '0;
        if (even_load)
            even_hit[reg_dst] = 1'b1;
        if (odd_set_valid)
            odd_hit[odd_set_dst] = 1'b1;
    end

    // busy reflects whether any producer is still in flight.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            busy = busy | (cnt[i] != 3'd0);
    end

    // Scoreboard update: a load wins over the decrement, and when both pipes
    // target the same register the longer wait is kept. A newer even write to
    // the same register simply overwrites (WAW never stalls).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                cnt[i] <= 3'd0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (even_hit[i] && odd_hit[i])
                    cnt[i] <= (even_val > odd_val) ? even_val : odd_val;
                else if (even_hit[i])
                    cnt[i] <= even_val;
                else if (odd_hit[i])
                    cnt[i] <= odd_val;
                else if (cnt[i] != 3'd0)
                    cnt[i] <= cnt[i] - 3'd1;
            end
        end
    end

    // Issue register: fields are captured on acceptance and held otherwise.
    // Nops never report a register write even if decode flagged one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_instr_id <= 7'd0;
            out_unit_id  <= 3'd0;
            out_reg_dst  <= 7'd0;
            out_latency  <= 4'd0;
            out_reg_wr   <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                out_instr_id <= instr_id;
                out_unit_id  <= unit_id;
                out_reg_dst  <= reg_dst;
                out_latency  <= latency;
                out_reg_wr   <= reg_wr && !is_nop;
            end
        end
    end

    // Count every cycle an offered instruction was held back, sticking at max.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_count <= 32'd0;
        else if (in_valid && hazard && stall_count != 32'hFFFF_FFFF)
            stall_count <= stall_count + 32'd1;
    end

endmodule
